// File: rtl/blackjack_pkg.sv
// Shared types, slot layout and card scoring for the Blackjack hand-building stage.
package blackjack_pkg;

  typedef logic [3:0] rank_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_e;

  localparam int unsigned NUM_SLOTS   = 22;
  localparam int unsigned DEALER_BASE = 0;
  localparam int unsigned PLAYER_BASE = 11;
  localparam int unsigned NUM_RANKS   = 13;
  localparam logic [15:0] LFSR_MASK   = 16'hB400;

  // Ace counts 1 here; the soft +10 is applied on the totals.
  function automatic logic [3:0] card_points(input rank_t r);
    if (r >= 4'd10) return 4'd10;
    return r;
  endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running 16-bit Galois LFSR (right shift, feedback mask applied when the LSB is 1).
module card_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] MASK = 16'hB400
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] lfsr
);

  always_ff @(posedge clk) begin
    if (reset) lfsr <= SEED;
    else if (lfsr[0]) lfsr <= (lfsr >> 1) ^ MASK;
    else lfsr <= lfsr >> 1;
  end

endmodule

// File: rtl/blackjack_hand_dealer.sv
// Deals LFSR-drawn ranks into the dealer/player hands and publishes slots, counts and totals.
// Optional finite 52-card deck tracking is enabled with `define DECK_TRACK_EN.
module blackjack_hand_dealer
  import blackjack_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int unsigned HAND_SLOTS = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_round,
  input  logic       shuffle,
  input  logic       deal_req,
  input  logic       deal_to_dealer,
  output logic       deal_ack,
  output logic       deal_err,
  output rank_t      dealt_rank,
  output logic       busy,
  output rank_t      card_values [0:NUM_SLOTS-1],
  output logic [3:0] dealer_card_count,
  output logic [3:0] player_card_count,
  output logic [6:0] dealer_total,
  output logic [6:0] player_total
);

  localparam logic [0:0] S_IDLE = IDLE;
  localparam logic [0:0] S_DRAW = DRAW;

  logic [0:0]  state, state_nx;
  logic [15:0] lfsr;
  logic        target_dealer;
  logic [6:0]  dealer_hard, player_hard;
  logic        dealer_ace, player_ace;
  rank_t       cand_rank;
  logic        cand_ok;
  logic        deck_avail;
  logic        req_full;
  logic        load_target;
  logic        commit;
  logic        err_c;
  logic [4:0]  write_idx;
  logic        unused_lfsr_hi;

  card_lfsr #(
    .SEED (LFSR_SEED),
    .MASK (LFSR_MASK)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .lfsr  (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[15:4];
  assign cand_rank      = rank_t'(lfsr[3:0] + 4'd1);

`ifdef DECK_TRACK_EN
  logic [2:0] deck_rem [NUM_RANKS];
  logic [2:0] rem_sel;
  logic       any_left;

  // A pending shuffle counts as a full deck for this cycle's candidate.
  always_comb begin
    rem_sel  = 3'd0;
    any_left = 1'b0;
    for (int unsigned i = 0; i < NUM_RANKS; i++) begin
      if (lfsr[3:0] == 4'(i)) rem_sel = deck_rem[i];
      if (deck_rem[i] != 3'd0) any_left = 1'b1;
    end
    cand_ok    = (lfsr[3:0] <= 4'd12) && (shuffle || (rem_sel != 3'd0));
    deck_avail = shuffle || any_left;
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_RANKS; i++) begin
      if (reset)
        deck_rem[i] <= 3'd4;
      else if (commit && (lfsr[3:0] == 4'(i)))
        deck_rem[i] <= (shuffle ? 3'd4 : deck_rem[i]) - 3'd1;
      else if (shuffle)
        deck_rem[i] <= 3'd4;
    end
  end
`else
  logic unused_shuffle;

  assign unused_shuffle = shuffle;
  assign cand_ok        = (lfsr[3:0] <= 4'd12);
  assign deck_avail     = 1'b1;
`endif

  assign req_full = deal_to_dealer ? (dealer_card_count >= 4'(HAND_SLOTS))
                                   : (player_card_count >= 4'(HAND_SLOTS));

  assign write_idx = target_dealer ? 5'(DEALER_BASE) + 5'(dealer_card_count)
                                   : 5'(PLAYER_BASE) + 5'(player_card_count);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else state <= state_nx;
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_nx    = state;
    load_target = 1'b0;
    commit      = 1'b0;
    err_c       = 1'b0;
    case (state)
      S_IDLE: begin
        if (deal_req && !deal_ack && !new_round) begin
          if (req_full || !deck_avail) begin
            err_c = 1'b1;
          end else begin
            load_target = 1'b1;
            state_nx    = S_DRAW;
          end
        end
      end
      S_DRAW: begin
        if (new_round) begin
          state_nx = S_IDLE;
        end else if (cand_ok) begin
          commit   = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deal_ack      <= 1'b0;
      deal_err      <= 1'b0;
      busy          <= 1'b0;
      dealt_rank    <= '0;
      target_dealer <= 1'b0;
    end else begin
      deal_ack <= commit || err_c;
      deal_err <= err_c;
      busy     <= (state_nx == S_DRAW);
      if (load_target) target_dealer <= deal_to_dealer;
      if (commit) dealt_rank <= cand_rank;
    end
  end

  // Hand storage: slots, counts, hard sums and ace flags commit together.
  always_ff @(posedge clk) begin
    if (reset || new_round) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) card_values[i] <= '0;
      dealer_card_count <= '0;
      player_card_count <= '0;
      dealer_hard       <= '0;
      player_hard       <= '0;
      dealer_ace        <= 1'b0;
      player_ace        <= 1'b0;
    end else if (commit) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (write_idx == 5'(i)) card_values[i] <= cand_rank;
      end
      if (target_dealer) begin
        dealer_card_count <= dealer_card_count + 4'd1;
        dealer_hard       <= dealer_hard + 7'(card_points(cand_rank));
        if (cand_rank == 4'd1) dealer_ace <= 1'b1;
      end else begin
        player_card_count <= player_card_count + 4'd1;
        player_hard       <= player_hard + 7'(card_points(cand_rank));
        if (cand_rank == 4'd1) player_ace <= 1'b1;
      end
    end
  end

  // One ace may count 11 while the hand stays at or below 21.
  assign dealer_total = (dealer_ace && (dealer_hard <= 7'd11)) ? dealer_hard + 7'd10 : dealer_hard;
  assign player_total = (player_ace && (player_hard <= 7'd11)) ? player_hard + 7'd10 : player_hard;

endmodule

// File: tb/tb_blackjack_hand_dealer.sv
// Randomized scoreboard bench for blackjack_hand_dealer with a list-based hand model and reference LFSR.
module tb_blackjack_hand_dealer;

  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          SLOTS = 11;
  localparam int          BOUND = 2000;

  logic       clk = 1'b0;
  logic       reset, new_round, shuffle, deal_req, deal_to_dealer;
  logic       deal_ack, deal_err, busy;
  logic [3:0] dealt_rank;
  logic [3:0] card_values [0:21];
  logic [3:0] dealer_card_count, player_card_count;
  logic [6:0] dealer_total, player_total;

  blackjack_hand_dealer #(.LFSR_SEED(SEED), .HAND_SLOTS(SLOTS)) dut (
    .clk               (clk),
    .reset             (reset),
    .new_round         (new_round),
    .shuffle           (shuffle),
    .deal_req          (deal_req),
    .deal_to_dealer    (deal_to_dealer),
    .deal_ack          (deal_ack),
    .deal_err          (deal_err),
    .dealt_rank        (dealt_rank),
    .busy              (busy),
    .card_values       (card_values),
    .dealer_card_count (dealer_card_count),
    .player_card_count (player_card_count),
    .dealer_total      (dealer_total),
    .player_total      (player_total)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit to_dealer;
    bit err;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   dealer_h[$];
  int   player_h[$];
  int   deck_rem [1:13];
  int   rank_hist [1:13];
  int   clr_seq  = 0;
  int   shuf_seq = 0;

  logic [15:0] m_lfsr, m_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic [15:0] n;
    n = v >> 1;
    if (v[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  // Best hand value straight from the card list.
  function automatic int hand_total(input int h[$]);
    int  sum = 0;
    bit  ace = 0;
    foreach (h[i]) begin
      sum += (h[i] > 10) ? 10 : h[i];
      if (h[i] == 1) ace = 1;
    end
    if (ace && (sum + 10 <= 21)) return sum + 10;
    return sum;
  endfunction

  function automatic int deck_left();
    int s = 0;
    for (int r = 1; r <= 13; r++) s += deck_rem[r];
    return s;
  endfunction

  // Reference LFSR; m_prev is the value the DUT saw in the previous cycle.
  always @(posedge clk) begin
    m_prev <= m_lfsr;
    m_lfsr <= reset ? SEED : lfsr_next(m_lfsr);
  end

  // Monitor: pops one expectation per ack and checks the whole visible hand state.
  initial begin
    int   seen_clr = 0;
    int   seen_shuf = 0;
    int   r, bad, ex;
    exp_t e;
    for (int k = 1; k <= 13; k++) begin
      deck_rem[k]  = 4;
      rank_hist[k] = 0;
    end
    forever begin
      @(negedge clk);
      if (clr_seq != seen_clr) begin
        seen_clr = clr_seq;
        dealer_h.delete();
        player_h.delete();
      end
      if (shuf_seq != seen_shuf) begin
        seen_shuf = shuf_seq;
        for (int k = 1; k <= 13; k++) deck_rem[k] = 4;
      end
      if (deal_ack === 1'b1) begin
        chk("ack_expected", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("deal_err", deal_err, e.err);
          if (!e.err && deal_err === 1'b0) begin
            r = int'(dealt_rank);
            chk("rank_from_lfsr", dealt_rank, 32'(m_prev[3:0]) + 1);
            chk("rank_range", (r >= 1 && r <= 13), 1);
            if (r >= 1 && r <= 13) begin
`ifdef DECK_TRACK_EN
              chk("rank_available", deck_rem[r] > 0, 1);
              deck_rem[r]--;
`endif
              rank_hist[r]++;
            end
            if (e.to_dealer) dealer_h.push_back(r);
            else player_h.push_back(r);
          end
          chk("dealer_count", dealer_card_count, dealer_h.size());
          chk("player_count", player_card_count, player_h.size());
          chk("dealer_total", dealer_total, hand_total(dealer_h));
          chk("player_total", player_total, hand_total(player_h));
          bad = 0;
          for (int i = 0; i < 22; i++) begin
            if (i < 11) ex = (i < dealer_h.size()) ? dealer_h[i] : 0;
            else ex = (i - 11 < player_h.size()) ? player_h[i - 11] : 0;
            if (card_values[i] !== 4'(ex)) bad++;
          end
          chk("slot_mismatches", bad, 0);
        end
      end
    end
  end

  task automatic check_clear(input string tag);
    int bad = 0;
    for (int i = 0; i < 22; i++) if (card_values[i] !== 4'd0) bad++;
    chk({tag, "_slots"}, bad, 0);
    chk({tag, "_counts"}, {dealer_card_count, player_card_count}, 0);
    chk({tag, "_totals"}, {dealer_total, player_total}, 0);
    chk({tag, "_ack"}, {deal_ack, deal_err, busy}, 0);
  endtask

  task automatic pulse_new_round(input string tag);
    @(negedge clk);
    new_round = 1'b1;
    clr_seq++;
    @(negedge clk);
    new_round = 1'b0;
    check_clear(tag);
  endtask

  task automatic do_shuffle();
    @(negedge clk);
    shuffle = 1'b1;
    shuf_seq++;
    @(negedge clk);
    shuffle = 1'b0;
  endtask

  // Issue one request, push its expectation, wait (bounded) for the ack.
  task automatic deal(input bit to_d, output bit got_err);
    int  lat = 0;
    bit  seen = 0;
    bit  full, ex_err;
    full   = (to_d ? dealer_h.size() : player_h.size()) >= SLOTS;
    ex_err = full;
`ifdef DECK_TRACK_EN
    if (deck_left() == 0) ex_err = 1;
`endif
    @(negedge clk);
    deal_req       = 1'b1;
    deal_to_dealer = to_d;
    sb_q.push_back('{to_dealer: to_d, err: ex_err});
    while (!seen && lat < BOUND) begin
      @(negedge clk);
      lat++;
      if (deal_ack === 1'b1) seen = 1;
    end
    got_err  = deal_err;
    deal_req = 1'b0;
    chk("ack_within_bound", seen, 1);
    if (seen) begin
      if (ex_err) chk("err_latency", lat, 1);
      else chk("deal_latency_ge2", lat >= 2, 1);
    end
    @(negedge clk);
  endtask

  initial begin
    bit   e;
    int   base_hist [1:13];
    int   cnt, bad;
    logic [3:0] snap [0:10];
    reset = 1'b1; new_round = 1'b0; shuffle = 1'b0; deal_req = 1'b0; deal_to_dealer = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_clear("reset");
    chk("reset_dealt_rank", dealt_rank, 0);

    deal(1'b1, e);
    deal(1'b0, e);
    chk("first_dealer_slot_nonzero", card_values[0] != 4'd0, 1);
    chk("first_player_slot_nonzero", card_values[11] != 4'd0, 1);
    chk("first_counts", {dealer_card_count, player_card_count}, {4'd1, 4'd1});

    while (dealer_h.size() < SLOTS && n_fail == 0) deal(1'b1, e);
    for (int i = 0; i < 11; i++) snap[i] = card_values[i];
    deal(1'b1, e);
    chk("full_hand_err", e, 1);
    chk("full_hand_count", dealer_card_count, SLOTS);
    bad = 0;
    for (int i = 0; i < 11; i++) if (card_values[i] !== snap[i]) bad++;
    chk("full_hand_slots_kept", bad, 0);
    pulse_new_round("round_clear");

`ifdef DECK_TRACK_EN
    do_shuffle();
`endif
    // Abort an in-flight draw with new_round.
    @(negedge clk);
    deal_req = 1'b1;
    deal_to_dealer = 1'b0;
    @(negedge clk);
    chk("busy_in_draw", busy, 1);
    deal_req  = 1'b0;
    new_round = 1'b1;
    clr_seq++;
    @(negedge clk);
    new_round = 1'b0;
    check_clear("abort");
    repeat (3) @(negedge clk);
    chk("abort_no_late_ack", deal_ack, 0);

    for (int rnd = 0; rnd < 4; rnd++) begin
      pulse_new_round("rand_round");
      repeat ($urandom_range(8, 20)) deal(1'($urandom_range(0, 1)), e);
    end

`ifdef DECK_TRACK_EN
    do_shuffle();
    pulse_new_round("deck_round");
    for (int k = 1; k <= 13; k++) base_hist[k] = rank_hist[k];
    cnt = 0;
    while (cnt < 52) begin
      if (dealer_h.size() < SLOTS) begin deal(1'b1, e); cnt++; end
      else if (player_h.size() < SLOTS) begin deal(1'b0, e); cnt++; end
      else pulse_new_round("deck_refill_round");
    end
    bad = 0;
    for (int k = 1; k <= 13; k++) if (rank_hist[k] - base_hist[k] != 4) bad++;
    chk("deck_each_rank_4", bad, 0);
    pulse_new_round("deck_empty_round");
    deal(1'b1, e);
    chk("deck_53rd_err", e, 1);
    do_shuffle();
    deal(1'b1, e);
    chk("after_shuffle_ok", e, 0);
`else
    cnt = 0;
    for (int k = 1; k <= 13; k++) begin
      base_hist[k] = rank_hist[k];
      cnt += base_hist[k];
    end
    chk("hist_matches_deals", cnt > 0, 1);
`endif

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/blackjack_hand_dealer.md
# blackjack_hand_dealer

Upstream hand-building stage of the Blackjack game. On a deal request it draws a pseudo-random card rank from a free-running LFSR and appends it to the dealer or player hand. It publishes the 22-slot card array and the per-hand counts consumed by the card layout stage, plus running hand totals for the game FSM.

## Interface
- `LFSR_SEED`, default 16'hACE1: LFSR value after reset; must be nonzero.
- `HAND_SLOTS`, default 11: maximum number of cards per hand.
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-high reset.
- `new_round`  in  1: pulse; clears both hands. Does not touch the deck.
- `shuffle`  in  1: pulse; refills the deck (only meaningful with `DECK_TRACK_EN`).
- `deal_req`  in  1: level; held high until `deal_ack`.
- `deal_to_dealer`  in  1: target hand, sampled when the request is accepted (1 = dealer).
- `deal_ack`  out  1: one-cycle completion pulse.
- `deal_err`  out  1: valid only with `deal_ack`; 1 = no card dealt.
- `dealt_rank`  out  4: rank of the last card dealt; held until the next deal.
- `busy`  out  1: high while state is DRAW.
- `card_values[0:21]`  out  4 each: slots 0–10 are dealer cards, 11–21 are player cards; 0 = empty, 1–13 = A..K.
- `dealer_card_count`, `player_card_count`  out  4 each: number of cards in each hand, 0–11.
- `dealer_total`, `player_total`  out  7 each: best Blackjack value of each hand.

## Operation
- **LFSR.** 16-bit Galois LFSR, mask 16'hB400, steps every cycle including during idle.
  - Candidate rank = `lfsr[3:0] + 1`.
  - The candidate is valid if `lfsr[3:0] <= 12` and, with tracking enabled, that rank is not exhausted.
- **State machine: IDLE and DRAW.**
  - IDLE → DRAW: `deal_req` high, `deal_ack` low, `new_round` low, and the target hand is not full. The target is latched on this transition.
  - IDLE, target hand full (count == `HAND_SLOTS`): stay in IDLE; next cycle pulse `deal_ack` = 1 and `deal_err` = 1. Nothing is written.
  - DRAW, candidate invalid: stay in DRAW and retry next cycle.
  - DRAW, candidate valid:
    - write the rank to slot `base + count`, where base is 0 for the dealer and 11 for the player;
    - increment the hand count, update the hand sum and ace flag, and load `dealt_rank`;
    - pulse `deal_ack`; `deal_err` = 0;
    - return to IDLE.
- **Handshake.** The requester drops `deal_req` in the cycle it sees `deal_ack`. A request still high during the ack cycle is ignored.
- **Priority.** `reset` > `new_round` > deal.
  - `new_round` in DRAW aborts the draw: no ack, no write, return to IDLE.
  - `new_round` clears all slots, counts, sums and ace flags to 0.
- **Totals.**
  - Card points: rank 1 = 1, ranks 2–10 = face value, ranks 11–13 = 10.
  - The hard sum is a 7-bit registered accumulator.
  - total = hard + 10 if the hand holds an ace and hard ≤ 11; otherwise total = hard.
  - Totals are combinational from registers. Maximum value is 110, so there is no overflow.
- **Reset values.**
  - All slots, counts, totals, `dealt_rank`, `deal_ack`, `deal_err` and `busy` reset to 0.
  - State resets to IDLE; the LFSR resets to `LFSR_SEED`; the deck resets to full.

## Timing
- Request accepted at edge E0. Minimum latency: slot, count and total are updated and `deal_ack` is high in the cycle after E1. Each rejected candidate adds one cycle.
- Full-hand error: `deal_ack`/`deal_err` are high in the cycle after E0.
- Hand outputs are all registered and change together on the commit edge.
- `new_round` takes effect at the next edge; outputs are zero in the following cycle.
- A `deal_req` in the same cycle as `new_round` is not accepted.

## Configuration
- **`DECK_TRACK_EN` defined:**
  - 13 per-rank 3-bit remaining counters, each reset to 4; `shuffle` reloads all to 4.
  - An exhausted rank rejects the candidate.
  - With all counters at 0, a request is answered like a full hand: `deal_ack` + `deal_err` the cycle after acceptance.
  - `shuffle` in DRAW is applied before the candidate check in the same cycle.
- **Undefined:** infinite deck. `shuffle` is ignored, and `deal_err` fires only on a full hand.

## Structure
- Package `blackjack_pkg` holds:
  - `rank_t` (4-bit);
  - `NUM_SLOTS = 22`, `DEALER_BASE = 0`, `PLAYER_BASE = 11`;
  - function `card_points(rank_t)` returning 4 bits;
  - the state enum `{IDLE, DRAW}`.
- Sub-module `card_lfsr` (parameters `SEED`, `MASK`; ports `clk`, `reset`, `lfsr[15:0]`).

## Test plan
- Reset, then idle 10 cycles → all slots, counts, totals, ack and err are 0.
- Deal to dealer, then to player → `card_values[0]` and `card_values[11]` are nonzero, each count is 1, ack latency ≥ 2 cycles, and totals match a bench model driven by `dealt_rank`.
- 11 dealer deals, then a 12th → 12th gets ack + err in 1 cycle, count stays 11, `card_values[0:10]` unchanged.
- `new_round` asserted while `busy` → no ack, counts 0, all slots 0 on the next cycle.
- Soft-ace check: scoreboard every deal; a hand with hard 7 plus an ace must report 17, and after hard reaches 12 it must report hard.
- With `DECK_TRACK_EN`: 52 deals across rounds without `shuffle` → each rank appears exactly 4 times; the 53rd deal gets ack + err; after `shuffle` the next deal succeeds.
